// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Pipeline controller for the ysyx_23060072 core: long-latency scoreboard, RAW/WAW stall, redirect flush sequencing.
// Optional PIPE_CTRL_PERF_EN adds stall/redirect performance counters.
module ysyx_23060072_pipe_ctrl #(
    parameter int unsigned REG_NUM      = 16,
    parameter int unsigned FLUSH_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_issue_i,
    input  logic [4:0]         id_rs1_addr_i,
    input  logic [4:0]         id_rs2_addr_i,
    input  logic               id_has_rs1_i,
    input  logic               id_has_rs2_i,
    input  logic               id_wb_flag_i,
    input  logic [4:0]         id_wb_addr_i,
    input  logic               id_long_i,
    input  logic               long_done_i,
    input  logic [4:0]         long_done_addr_i,
    input  logic               ex_jump_flag_i,
    input  logic [31:0]        ex_jump_pc_i,
    input  logic               clint_jump_flag_i,
    input  logic [31:0]        clint_jump_pc_i,
    input  logic               clint_hold_flag_i,
    input  logic               lsu_hold_flag_i,
    input  logic               mdu_hold_flag_i,
    output logic               if_hold_flag_o,
    output logic               id_hold_flag_o,
    output logic               ex_hold_flag_o,
    output logic               ex_bubble_o,
    output logic               clean_flag_o,
    output logic               redirect_o,
    output logic [31:0]        jump_pc_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o,
`endif
    output logic [REG_NUM-1:0] busy_o
);

    localparam int unsigned AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int unsigned CW = 3;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [REG_NUM-1:0] busy;

    logic               freeze;
    logic [REG_NUM-1:0] done_mask;
    logic [REG_NUM-1:0] busy_eff;
    logic [REG_NUM-1:0] set_mask;
    logic               raw;
    logic               hazard;
    logic               redir_req;
    logic               accept;
    logic [31:0]        redir_pc;
    logic               issue;

    // One-hot of a register address; addresses outside the tracked file map to nothing.
    function automatic logic [REG_NUM-1:0] reg_mask(input logic [4:0] addr);
        logic [REG_NUM-1:0] m;
        m = '0;
        if (32'(addr) < REG_NUM) begin
            m[addr[AW-1:0]] = 1'b1;
        end
        return m;
    endfunction

    // Hazard, redirect arbitration and scoreboard update terms.
    always_comb begin
        freeze    = lsu_hold_flag_i | mdu_hold_flag_i | clint_hold_flag_i;
        done_mask = long_done_i ? reg_mask(long_done_addr_i) : '0;
        busy_eff  = busy & ~done_mask;
        raw       = (id_has_rs1_i & (|(busy_eff & reg_mask(id_rs1_addr_i))))
                  | (id_has_rs2_i & (|(busy_eff & reg_mask(id_rs2_addr_i))))
                  | (id_wb_flag_i & (|(busy_eff & reg_mask(id_wb_addr_i))));
        hazard    = (state == RUN) & id_issue_i & ~freeze & raw;
        // While flushing, EX holds a squashed slot, so only a trap can redirect again.
        redir_req = clint_jump_flag_i | (ex_jump_flag_i & (state == RUN));
        accept    = redir_req & ~freeze;
        redir_pc  = clint_jump_flag_i ? clint_jump_pc_i : ex_jump_pc_i;
        issue     = id_issue_i & ~hazard & ~freeze & (state == RUN) & ~accept;
        set_mask  = '0;
        if (issue && id_wb_flag_i && id_long_i && (id_wb_addr_i != 5'd0)) begin
            set_mask = reg_mask(id_wb_addr_i);
        end
    end

    // Flush sequencing: counter holds remaining FLUSH cycles, paused by freeze.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            if (FLUSH_STAGES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = CW'(FLUSH_STAGES - 1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end else if ((state == FLUSH) && !freeze) begin
            cnt_nxt = CW'(cnt - CW'(1));
            if (cnt_nxt == '0) begin
                state_nxt = RUN;
            end
        end
    end

    // Stage control outputs, forced quiet while reset is asserted.
    always_comb begin
        if_hold_flag_o = 1'b0;
        id_hold_flag_o = 1'b0;
        ex_hold_flag_o = 1'b0;
        ex_bubble_o    = 1'b0;
        clean_flag_o   = 1'b0;
        redirect_o     = 1'b0;
        jump_pc_o      = 32'd0;
        if (rst_n) begin
            if_hold_flag_o = freeze | (hazard & ~accept);
            id_hold_flag_o = freeze | (hazard & ~accept);
            ex_hold_flag_o = freeze;
            ex_bubble_o    = hazard & ~accept;
            clean_flag_o   = accept | (state == FLUSH);
            redirect_o     = accept;
            jump_pc_o      = accept ? redir_pc : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_eff | set_mask;
        end
    end

    assign busy_o = busy;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Free-running event counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (hazard || freeze) stall_cnt <= stall_cnt + 32'd1;
            if (accept)           flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Directed bench for ysyx_23060072_pipe_ctrl (REG_NUM=16, FLUSH_STAGES=2).
// Counter checks are compiled in when PIPE_CTRL_PERF_EN is defined.
module tb_ysyx_23060072_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_issue_i, id_has_rs1_i, id_has_rs2_i, id_wb_flag_i, id_long_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_wb_addr_i, long_done_addr_i;
    logic        long_done_i, ex_jump_flag_i, clint_jump_flag_i;
    logic [31:0] ex_jump_pc_i, clint_jump_pc_i;
    logic        clint_hold_flag_i, lsu_hold_flag_i, mdu_hold_flag_i;
    logic        if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, ex_bubble_o;
    logic        clean_flag_o, redirect_o;
    logic [31:0] jump_pc_o;
    logic [15:0] busy_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    ysyx_23060072_pipe_ctrl #(.REG_NUM(16), .FLUSH_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_issue_i(id_issue_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_has_rs1_i(id_has_rs1_i), .id_has_rs2_i(id_has_rs2_i),
        .id_wb_flag_i(id_wb_flag_i), .id_wb_addr_i(id_wb_addr_i), .id_long_i(id_long_i),
        .long_done_i(long_done_i), .long_done_addr_i(long_done_addr_i),
        .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_pc_i(ex_jump_pc_i),
        .clint_jump_flag_i(clint_jump_flag_i), .clint_jump_pc_i(clint_jump_pc_i),
        .clint_hold_flag_i(clint_hold_flag_i), .lsu_hold_flag_i(lsu_hold_flag_i),
        .mdu_hold_flag_i(mdu_hold_flag_i),
        .if_hold_flag_o(if_hold_flag_o), .id_hold_flag_o(id_hold_flag_o),
        .ex_hold_flag_o(ex_hold_flag_o), .ex_bubble_o(ex_bubble_o),
        .clean_flag_o(clean_flag_o), .redirect_o(redirect_o), .jump_pc_o(jump_pc_o),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_issue_i = 0; id_has_rs1_i = 0; id_has_rs2_i = 0; id_wb_flag_i = 0; id_long_i = 0;
        id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_wb_addr_i = 0;
        long_done_i = 0; long_done_addr_i = 0;
        ex_jump_flag_i = 0; ex_jump_pc_i = 0; clint_jump_flag_i = 0; clint_jump_pc_i = 0;
        clint_hold_flag_i = 0; lsu_hold_flag_i = 0; mdu_hold_flag_i = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0; idle();
        tick(); tick();
        rst_n = 1;
    endtask

    // Drive a long-latency write issue for rd.
    task automatic drive_long_wr(input logic [4:0] rd);
        idle(); id_issue_i = 1; id_wb_flag_i = 1; id_wb_addr_i = rd; id_long_i = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        tick(); tick();
        @(negedge clk);
        if (busy_o !== 16'h0) begin $display("FAIL reset_busy: got %h expected %h", busy_o, 16'h0); errors++; end checks++;
        if ({if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, ex_bubble_o, clean_flag_o, redirect_o} !== 6'b0) begin
            $display("FAIL reset_flags: got %b expected %b", {if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, ex_bubble_o, clean_flag_o, redirect_o}, 6'b0); errors++; end checks++;
        if (jump_pc_o !== 32'h0) begin $display("FAIL reset_pc: got %h expected %h", jump_pc_o, 32'h0); errors++; end checks++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_load_hazard();
        drive_long_wr(5'd5);
        @(negedge clk);
        if (id_hold_flag_o !== 1'b0) begin $display("FAIL load_issue_hold: got %b expected 0", id_hold_flag_o); errors++; end checks++;
        tick();
        idle(); id_issue_i = 1; id_has_rs1_i = 1; id_rs1_addr_i = 5'd5; id_wb_flag_i = 1; id_wb_addr_i = 5'd6;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (busy_o !== 16'h0020) begin $display("FAIL raw_busy%0d: got %h expected %h", i, busy_o, 16'h0020); errors++; end checks++;
            if ({if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, ex_bubble_o} !== 4'b1101) begin
                $display("FAIL raw_stall%0d: got %b expected %b", i, {if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, ex_bubble_o}, 4'b1101); errors++; end checks++;
            tick();
        end
        long_done_i = 1; long_done_addr_i = 5'd5;
        @(negedge clk);
        if ({id_hold_flag_o, ex_bubble_o} !== 2'b00) begin $display("FAIL raw_bypass: got %b expected %b", {id_hold_flag_o, ex_bubble_o}, 2'b00); errors++; end checks++;
        tick();
        idle();
        @(negedge clk);
        if (busy_o !== 16'h0) begin $display("FAIL raw_cleared: got %h expected %h", busy_o, 16'h0); errors++; end checks++;
        // WAW against an outstanding load to x8, via rs2-free write
        drive_long_wr(5'd8);
        tick();
        idle(); id_issue_i = 1; id_wb_flag_i = 1; id_wb_addr_i = 5'd8;
        @(negedge clk);
        if (id_hold_flag_o !== 1'b1) begin $display("FAIL waw_stall: got %b expected 1", id_hold_flag_o); errors++; end checks++;
        long_done_i = 1; long_done_addr_i = 5'd8;
        @(negedge clk);
        if (id_hold_flag_o !== 1'b0) begin $display("FAIL waw_bypass: got %b expected 0", id_hold_flag_o); errors++; end checks++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_jump();
        idle(); ex_jump_flag_i = 1; ex_jump_pc_i = 32'h8000_0040;
        @(negedge clk);
        if ({redirect_o, clean_flag_o} !== 2'b11) begin $display("FAIL jump_T_flags: got %b expected %b", {redirect_o, clean_flag_o}, 2'b11); errors++; end checks++;
        if (jump_pc_o !== 32'h8000_0040) begin $display("FAIL jump_T_pc: got %h expected %h", jump_pc_o, 32'h8000_0040); errors++; end checks++;
        tick();
        idle();
        @(negedge clk);
        if ({redirect_o, clean_flag_o} !== 2'b01) begin $display("FAIL jump_T1_flags: got %b expected %b", {redirect_o, clean_flag_o}, 2'b01); errors++; end checks++;
        tick();
        @(negedge clk);
        if (clean_flag_o !== 1'b0) begin $display("FAIL jump_T2_clean: got %b expected 0", clean_flag_o); errors++; end checks++;
    endtask

    task automatic test_priority();
        idle(); ex_jump_flag_i = 1; ex_jump_pc_i = 32'h8000_0040;
        clint_jump_flag_i = 1; clint_jump_pc_i = 32'h8000_0100;
        @(negedge clk);
        if (jump_pc_o !== 32'h8000_0100) begin $display("FAIL prio_pc: got %h expected %h", jump_pc_o, 32'h8000_0100); errors++; end checks++;
        if (redirect_o !== 1'b1) begin $display("FAIL prio_redir: got %b expected 1", redirect_o); errors++; end checks++;
        tick();
        idle();
        @(negedge clk);
        if ({redirect_o, clean_flag_o} !== 2'b01) begin $display("FAIL prio_single: got %b expected %b", {redirect_o, clean_flag_o}, 2'b01); errors++; end checks++;
        tick();
        @(negedge clk);
        if (clean_flag_o !== 1'b0) begin $display("FAIL prio_done: got %b expected 0", clean_flag_o); errors++; end checks++;
    endtask

    task automatic test_freeze();
        idle(); ex_jump_flag_i = 1; ex_jump_pc_i = 32'h8000_0040; lsu_hold_flag_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, redirect_o, clean_flag_o} !== 5'b11100) begin
                $display("FAIL freeze_c%0d: got %b expected %b", i, {if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, redirect_o, clean_flag_o}, 5'b11100); errors++; end checks++;
            tick();
        end
        lsu_hold_flag_i = 0;
        @(negedge clk);
        if ({redirect_o, ex_hold_flag_o} !== 2'b10 || jump_pc_o !== 32'h8000_0040) begin
            $display("FAIL freeze_release: got redir=%b hold=%b pc=%h expected redir=1 hold=0 pc=%h", redirect_o, ex_hold_flag_o, jump_pc_o, 32'h8000_0040); errors++; end checks++;
        tick();
        idle(); mdu_hold_flag_i = 1;
        @(negedge clk);
        if ({clean_flag_o, ex_hold_flag_o} !== 2'b11) begin $display("FAIL flush_freeze: got %b expected %b", {clean_flag_o, ex_hold_flag_o}, 2'b11); errors++; end checks++;
        tick();
        mdu_hold_flag_i = 0;
        @(negedge clk);
        if (clean_flag_o !== 1'b1) begin $display("FAIL flush_paused: got %b expected 1", clean_flag_o); errors++; end checks++;
        tick();
        @(negedge clk);
        if (clean_flag_o !== 1'b0) begin $display("FAIL flush_resume_end: got %b expected 0", clean_flag_o); errors++; end checks++;
    endtask

    task automatic test_clint_in_flush();
        idle(); ex_jump_flag_i = 1; ex_jump_pc_i = 32'h8000_0040;
        tick();
        idle(); clint_jump_flag_i = 1; clint_jump_pc_i = 32'h8000_0100;
        @(negedge clk);
        if ({redirect_o, clean_flag_o} !== 2'b11 || jump_pc_o !== 32'h8000_0100) begin
            $display("FAIL flush_trap: got redir=%b clean=%b pc=%h expected redir=1 clean=1 pc=%h", redirect_o, clean_flag_o, jump_pc_o, 32'h8000_0100); errors++; end checks++;
        tick();
        idle();
        @(negedge clk);
        if ({redirect_o, clean_flag_o} !== 2'b01) begin $display("FAIL flush_reload: got %b expected %b", {redirect_o, clean_flag_o}, 2'b01); errors++; end checks++;
        tick();
        @(negedge clk);
        if (clean_flag_o !== 1'b0) begin $display("FAIL flush_reload_end: got %b expected 0", clean_flag_o); errors++; end checks++;
    endtask

    task automatic test_set_clear();
        drive_long_wr(5'd7);
        tick();
        drive_long_wr(5'd7); long_done_i = 1; long_done_addr_i = 5'd7;
        @(negedge clk);
        if (busy_o !== 16'h0080 || id_hold_flag_o !== 1'b0) begin
            $display("FAIL setclr_pre: got busy=%h hold=%b expected busy=%h hold=0", busy_o, id_hold_flag_o, 16'h0080); errors++; end checks++;
        tick();
        idle(); long_done_i = 1; long_done_addr_i = 5'd7;
        @(negedge clk);
        if (busy_o !== 16'h0080) begin $display("FAIL setclr_wins: got %h expected %h", busy_o, 16'h0080); errors++; end checks++;
        tick();
        idle();
        @(negedge clk);
        if (busy_o !== 16'h0) begin $display("FAIL setclr_done: got %h expected %h", busy_o, 16'h0); errors++; end checks++;
        drive_long_wr(5'd20);
        tick();
        idle(); id_issue_i = 1; id_has_rs1_i = 1; id_rs1_addr_i = 5'd20; id_wb_flag_i = 1; id_wb_addr_i = 5'd20;
        @(negedge clk);
        if (busy_o !== 16'h0 || id_hold_flag_o !== 1'b0) begin
            $display("FAIL x20_untracked: got busy=%h hold=%b expected busy=0000 hold=0", busy_o, id_hold_flag_o); errors++; end checks++;
        tick();
        drive_long_wr(5'd0);
        tick();
        idle();
        @(negedge clk);
        if (busy_o !== 16'h0) begin $display("FAIL x0_never_busy: got %h expected %h", busy_o, 16'h0); errors++; end checks++;
    endtask

    task automatic test_reset_mid();
        drive_long_wr(5'd5);
        tick();
        idle(); ex_jump_flag_i = 1; ex_jump_pc_i = 32'h8000_0040;
        tick();
        idle(); mdu_hold_flag_i = 1; rst_n = 0;
        tick();
        idle(); rst_n = 1;
        @(negedge clk);
        if (busy_o !== 16'h0 || clean_flag_o !== 1'b0) begin
            $display("FAIL reset_mid: got busy=%h clean=%b expected busy=0000 clean=0", busy_o, clean_flag_o); errors++; end checks++;
        tick();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        drive_long_wr(5'd5);
        tick();
        idle(); id_issue_i = 1; id_has_rs1_i = 1; id_rs1_addr_i = 5'd5;
        tick(); tick(); tick();
        long_done_i = 1; long_done_addr_i = 5'd5;
        tick();
        for (int i = 0; i < 2; i++) begin
            idle(); ex_jump_flag_i = 1; ex_jump_pc_i = 32'h8000_0040;
            tick();
            idle();
            tick();
        end
        @(negedge clk);
        if (stall_cnt_o !== 32'd3) begin $display("FAIL perf_stall: got %0d expected 3", stall_cnt_o); errors++; end checks++;
        if (flush_cnt_o !== 32'd2) begin $display("FAIL perf_flush: got %0d expected 2", flush_cnt_o); errors++; end checks++;
        do_reset();
        @(negedge clk);
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            $display("FAIL perf_reset: got stall=%0d flush=%0d expected 0 0", stall_cnt_o, flush_cnt_o); errors++; end checks++;
        tick();
    endtask
`endif

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_load_hazard();
        test_jump();
        test_priority();
        test_freeze();
        test_clint_in_flush();
        test_set_clear();
        test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
